// File: rtl/board_controller.sv
// board_controller: tic-tac-toe game state (board, cursor, win/draw scan) for the VGA renderer
// Ports: clk/rst (async high); btn_next, btn_place raw buttons; player_address -> player combinational cell read;
//        sel_position cursor; pos1..pos3 winning line (F = none); turn, game_over, winner status.
module board_controller #(
  parameter int SYNC_STAGES  = 2,
  parameter int START_PLAYER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_place,
  input  logic [3:0] player_address,
  output logic [1:0] player,
  output logic [3:0] sel_position,
  output logic [3:0] pos1,
  output logic [3:0] pos2,
  output logic [3:0] pos3,
  output logic [1:0] turn,
  output logic       game_over,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
  // One nibble per cell index, lines in scan order.
  localparam logic [11:0] LINES [8] = '{12'h012, 12'h345, 12'h678, 12'h036,
                                        12'h147, 12'h258, 12'h048, 12'h246};
  state_t                 state_q;
  logic [8:0][1:0]        cells_q;
  logic [3:0]             sel_q, pos1_q, pos2_q, pos3_q, cnt_q;
  logic [1:0]             turn_q, winner_q;
  logic                   game_over_q;
  logic [2:0]             line_q;
  logic [SYNC_STAGES-1:0] nxt_sync_q, plc_sync_q;
  logic                   nxt_prev_q, plc_prev_q;
  logic                   next_p, place_p, hit;
  logic [11:0]            ln;
  assign next_p  = nxt_sync_q[SYNC_STAGES-1] & ~nxt_prev_q;
  assign place_p = plc_sync_q[SYNC_STAGES-1] & ~plc_prev_q;
  assign ln      = LINES[line_q];
  // During CHECK turn_q still holds the mark just placed.
  assign hit = (cells_q[ln[11:8]] == turn_q) && (cells_q[ln[7:4]] == turn_q) && (cells_q[ln[3:0]] == turn_q);
  assign player       = (player_address < 4'd9) ? cells_q[player_address] : 2'd0;
  assign sel_position = sel_q;
  assign pos1         = pos1_q;
  assign pos2         = pos2_q;
  assign pos3         = pos3_q;
  assign turn         = turn_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PLAY;
      cells_q     <= '0;
      sel_q       <= '0;
      pos1_q      <= 4'hF;
      pos2_q      <= 4'hF;
      pos3_q      <= 4'hF;
      cnt_q       <= '0;
      turn_q      <= 2'(START_PLAYER);
      winner_q    <= '0;
      game_over_q <= 1'b0;
      line_q      <= '0;
      nxt_sync_q  <= '0;
      plc_sync_q  <= '0;
      nxt_prev_q  <= 1'b0;
      plc_prev_q  <= 1'b0;
    end else begin
      nxt_sync_q <= {nxt_sync_q[SYNC_STAGES-2:0], btn_next};
      plc_sync_q <= {plc_sync_q[SYNC_STAGES-2:0], btn_place};
      nxt_prev_q <= nxt_sync_q[SYNC_STAGES-1];
      plc_prev_q <= plc_sync_q[SYNC_STAGES-1];
      case (state_q)
        PLAY: begin
          if (place_p && cells_q[sel_q] == 2'd0) begin
            cells_q[sel_q] <= turn_q;
            cnt_q          <= cnt_q + 4'(cnt_q != 4'd9);
            line_q         <= '0;
            state_q        <= CHECK;
          end else if (next_p && !place_p) begin
            sel_q <= (sel_q == 4'd8) ? 4'd0 : sel_q + 4'd1;
          end
        end
        CHECK: begin
          if (hit) begin
            pos1_q      <= ln[11:8];
            pos2_q      <= ln[7:4];
            pos3_q      <= ln[3:0];
            winner_q    <= turn_q;
            game_over_q <= 1'b1;
            state_q     <= WIN;
          end else if (line_q == 3'd7) begin
            if (cnt_q == 4'd9) begin
              winner_q    <= '0;
              game_over_q <= 1'b1;
              state_q     <= DRAW;
            end else begin
              turn_q  <= turn_q ^ 2'b11;
              state_q <= PLAY;
            end
          end else begin
            line_q <= line_q + 3'd1;
          end
        end
        default: begin
          if (place_p) begin
            cells_q     <= '0;
            pos1_q      <= 4'hF;
            pos2_q      <= 4'hF;
            pos3_q      <= 4'hF;
            winner_q    <= '0;
            game_over_q <= 1'b0;
            cnt_q       <= '0;
            turn_q      <= 2'(START_PLAYER);
            sel_q       <= '0;
            state_q     <= PLAY;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: scoreboard bench for board_controller
module tb_board_controller;
  logic       clk = 0, rst = 1, btn_next = 0, btn_place = 0;
  logic [3:0] player_address = 0;
  logic [1:0] player, turn, winner;
  logic [3:0] sel_position, pos1, pos2, pos3;
  logic       game_over;
  int cyc = 0, checks = 0, errors = 0, cur = 0;
  typedef struct {string name; int sel; int exp; int due;} chk_t;
  chk_t sb[$];
  board_controller #(.SYNC_STAGES(2), .START_PLAYER(1)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_place(btn_place),
    .player_address(player_address), .player(player), .sel_position(sel_position),
    .pos1(pos1), .pos2(pos2), .pos3(pos3), .turn(turn), .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int obs(int s);
    case (s)
      0: return int'(sel_position);
      1: return int'(pos1);
      2: return int'(pos2);
      3: return int'(pos3);
      4: return int'(turn);
      5: return int'(game_over);
      6: return int'(winner);
      default: return int'(player);
    endcase
  endfunction
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        checks++;
        if (obs(sb[i].sel) != sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, obs(sb[i].sel), sb[i].exp, cyc);
        end
        sb.delete(i);
      end else i++;
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_o(string name, int sel, int v);
    sb.push_back('{name, sel, v, cyc});
  endtask
  task automatic look(int a, int v, string name);
    player_address = 4'(a);
    expect_o(name, 7, v);
    @(negedge clk);
    #1;
  endtask
  task automatic expect_pos(int a, int b, int c, string name);
    expect_o({name, "_pos1"}, 1, a);
    expect_o({name, "_pos2"}, 2, b);
    expect_o({name, "_pos3"}, 3, c);
  endtask
  task automatic press_next();
    btn_next = 1;
    tick(1);
    btn_next = 0;
    tick(2);
  endtask
  task automatic press_place();
    btn_place = 1;
    tick(1);
    btn_place = 0;
    tick(2);
  endtask
  task automatic goto_cell(int c);
    while (cur != c) begin
      press_next();
      cur = (cur + 1) % 9;
    end
  endtask
  task automatic place(int c);
    goto_cell(c);
    press_place();
    tick(9);
  endtask
  task automatic do_reset();
    rst = 1;
    tick(2);
    rst = 0;
    cur = 0;
    tick(1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int xs[9];
    tick(2);
    expect_o("rst_sel", 0, 0);
    expect_pos(15, 15, 15, "rst");
    expect_o("rst_turn", 4, 1);
    expect_o("rst_go", 5, 0);
    expect_o("rst_win", 6, 0);
    look(4, 0, "rst_cell4");
    rst = 0;
    tick(1);
    // cursor stepping and latency
    btn_next = 1;
    tick(1);
    btn_next = 0;
    tick(1);
    expect_o("next_lat_early", 0, 0);
    tick(1);
    expect_o("next_lat_land", 0, 1);
    for (int i = 2; i <= 9; i++) begin
      press_next();
      expect_o($sformatf("next_step%0d", i), 0, i % 9);
    end
    btn_next = 1;
    tick(100);
    expect_o("hold_sel", 0, 1);
    btn_next = 0;
    tick(3);
    expect_o("hold_sel_after", 0, 1);
    cur = 1;
    // first move and occupied-cell rejection
    goto_cell(4);
    press_place();
    expect_o("place_turn_during", 4, 1);
    look(4, 1, "place_cell4");
    tick(9);
    expect_o("turn_after_check", 4, 2);
    press_place();
    tick(9);
    expect_o("occupied_turn", 4, 2);
    expect_o("occupied_go", 5, 0);
    look(4, 1, "occupied_cell4");
    // row win 0-1-2
    do_reset();
    place(0); place(3); place(1); place(4); place(2);
    expect_pos(0, 1, 2, "row");
    expect_o("row_winner", 6, 1);
    expect_o("row_go", 5, 1);
    look(15, 0, "addr15");
    look(9, 0, "addr9");
    press_next();
    tick(1);
    expect_o("won_next_ignored", 0, 2);
    press_place();
    cur = 0;
    expect_o("newgame_go", 5, 0);
    expect_o("newgame_sel", 0, 0);
    expect_o("newgame_turn", 4, 1);
    expect_pos(15, 15, 15, "newgame");
    look(0, 0, "newgame_cell0");
    // draw
    xs = '{4, 0, 8, 2, 1, 7, 6, 3, 5};
    foreach (xs[i]) place(xs[i]);
    expect_o("draw_go", 5, 1);
    expect_o("draw_winner", 6, 0);
    expect_pos(15, 15, 15, "draw");
    look(7, 2, "draw_cell7");
    press_place();
    cur = 0;
    expect_o("draw_new_go", 5, 0);
    expect_o("draw_new_turn", 4, 1);
    expect_o("draw_new_sel", 0, 0);
    for (int a = 0; a < 9; a++) look(a, 0, $sformatf("draw_new_cell%0d", a));
    // column 2-5-8 wins before diagonal 2-4-6
    xs = '{4, 0, 6, 1, 5, 3, 8, 7, 2};
    foreach (xs[i]) place(xs[i]);
    expect_pos(2, 5, 8, "scan_order");
    expect_o("scan_winner", 6, 1);
    press_place();
    cur = 0;
    // async reset during CHECK
    press_next();
    cur = 1;
    press_place();
    tick(3);
    expect_o("mid_check_go", 5, 0);
    #1;
    rst = 1;
    #1;
    expect_o("async_sel", 0, 0);
    expect_o("async_turn", 4, 1);
    expect_pos(15, 15, 15, "async");
    look(1, 0, "async_cell1");
    tick(1);
    rst = 0;
    cur = 0;
    tick(12);
    expect_o("post_rst_turn", 4, 1);
    expect_o("post_rst_go", 5, 0);
    look(1, 0, "post_rst_cell1");
    tick(2);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_controller.md
Name: board_controller

Overview:
- Game-state stage directly upstream of the VGA top level.
- Holds the 3x3 tic-tac-toe board and the selection cursor, and accepts player moves from two push buttons.
- Scans for wins and draws, and drives the cursor index, winning-line indices and board-cell read data that the renderer consumes.
- Runs on the same 25 MHz pixel clock as the renderer; the board read port is combinational so the renderer can use it within one pixel cycle.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each button synchronizer (minimum 2)
START_PLAYER, 1, mark code of the player who moves first after reset or a new game (1 or 2)

Ports:
clk  input  1  pixel clock (25 MHz)
rst  input  1  asynchronous, active-high reset
btn_next  input  1  raw level, asynchronous; rising edge advances the cursor
btn_place  input  1  raw level, asynchronous; rising edge places a mark, or starts a new game when the game is over
player_address  input  4  board cell read address from the renderer, 0..8
player  output  2  mark stored at player_address: 0 empty, 1 X, 2 O; reads 0 when the address is 9..15
sel_position  output  4  cursor cell index, 0..8
pos1, pos2, pos3  output  4 each  winning-line cell indices in ascending order; 4'hF when there is no win
turn  output  2  mark code of the player to move
game_over  output  1  high in WIN and DRAW
winner  output  2  mark code of the winner; 0 when there is no winner or on a draw

Behaviour:
- Reset (async assert) values:
  - all 9 cells = 0
  - sel_position = 0
  - pos1/pos2/pos3 = 4'hF
  - turn = START_PLAYER
  - game_over = 0, winner = 0
  - move count = 0
  - FSM = PLAY
  - synchronizer and edge registers = 0
- Reset asserted mid-CHECK or mid-game aborts everything and returns to the values above. Release is synchronous to clk.
- Buttons:
  - Each button passes through SYNC_STAGES flip-flops, then a rising-edge detector, giving a 1-cycle pulse.
  - The pulse occurs SYNC_STAGES+1 clk edges after the raw input rises.
  - A held button produces exactly one pulse.
- `player` read: purely combinational from the cell array. A cell write becomes visible on the cycle after the write edge.
- FSM states: PLAY, CHECK, WIN, DRAW.
- PLAY:
  - next pulse: sel_position = (sel_position == 8) ? 0 : sel_position + 1.
  - place pulse on an empty cell: write `turn` into the cell, increment move count, go to CHECK, clear the line index.
  - place pulse on an occupied cell: ignored, no state change.
  - next and place pulses in the same cycle: place has priority and the cursor does not move.
- CHECK:
  - Tests one line per cycle over 8 cycles, in this fixed order: 0-1-2, 3-4-5, 6-7-8, 0-3-6, 1-4-7, 2-5-8, 0-4-8, 2-4-6.
  - A line matches when all 3 cells equal the mark just placed.
  - First match: latch its indices into pos1..3, set winner = mark and game_over = 1, go to WIN. Remaining lines are not tested.
  - No match after line 7 with move count = 9: go to DRAW, game_over = 1, winner = 0.
  - No match after line 7 otherwise: toggle turn (1<->2), return to PLAY.
  - Worst-case CHECK latency is 8 cycles. Button pulses arriving during CHECK are dropped.
- WIN and DRAW:
  - next pulses are ignored; outputs hold.
  - place pulse starts a new game in one cycle: clear all cells, set pos1..3 = 4'hF, winner = 0, game_over = 0, move count = 0, turn = START_PLAYER, sel_position = 0, go to PLAY.
- Widths:
  - move count is 4 bits, saturating at 9.
  - Line index is 3 bits.
  - Cell codes are 2 bits; code 3 is never written.

Test Plan:
- Reset, then 9 next presses → sel_position steps 1..8 and then wraps to 0; each step lands SYNC_STAGES+1 cycles after its press; holding btn_next for 100 cycles gives exactly one step.
- Place at cell 4 → player_address=4 reads 1; after CHECK (8 cycles) turn=2; a place at cell 4 again → no change, turn stays 2, move count stays 1.
- Moves X0, O3, X1, O4, X2 → WIN on the first line checked: pos1..3=0,1,2, winner=1, game_over=1; later next presses leave sel_position unchanged.
- Move sequence X4, O0, X8, O2, X1, O7, X6, O3, X5 (no three-in-a-row) → DRAW: game_over=1, winner=0, pos1..3=F; a place press → all cells read 0, turn=1, sel_position=0, game_over=0.
- Win on diagonal 2-4-6 that also completes column 2-5-8 with the same placement → pos1..3=2,5,8, since that column precedes the diagonal in scan order.
- Assert rst during CHECK cycle 3 → all outputs return to reset values immediately and asynchronously; player_address 9..15 reads 0 at all times.
